// File: rtl/fd_corner_collector_if.sv
// Bundle of frame-control, pixel-result and corner-output signals between the
// FAST-9 detector top (master) and the corner collector (slave).
interface fd_corner_collector_if #(
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 16
);
   // Output handshake: a transfer happens on a rising edge where outValid and
   // outReady are both 1; while outValid && !outReady, outValid/outAddr hold,
   // and outValid never depends on outReady.
   logic              frameStart;
   logic              frameEnd;
   logic              inValid;
   logic              isCorner;
   logic [ADDR_W-1:0] refAddr;
   logic              outValid;
   logic              outReady;
   logic [ADDR_W-1:0] outAddr;
   logic [CNT_W-1:0]  cornerCount;
   logic              overflow;
   logic              busy;
   logic              frameDone;
   logic [1:0]        dbg_state;

   modport master (
      output frameStart, frameEnd, inValid, isCorner, refAddr, outReady,
      input  outValid, outAddr, cornerCount, overflow, busy, frameDone, dbg_state
   );

   modport slave (
      input  frameStart, frameEnd, inValid, isCorner, refAddr, outReady,
      output outValid, outAddr, cornerCount, overflow, busy, frameDone, dbg_state
   );
endinterface

// File: rtl/fd_corner_collector.sv
// Collects corner addresses from the FAST-9 detector into a first-word-fall-through
// FIFO and frames them with per-frame count, sticky overflow and a done pulse.
module fd_corner_collector #(
   parameter int ADDR_W = 15,
   parameter int DEPTH  = 64,
   parameter int CNT_W  = 16
) (
   input logic                  clock,
   input logic                  reset,
   fd_corner_collector_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [ADDR_W-1:0] mem_q [DEPTH];

   logic empty, full, pop, qual, push;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && bus.outReady;
   assign qual  = (state_q == COLLECT) && bus.inValid && bus.isCorner;
   assign push  = qual && (!full || pop);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
      out_addr_d = out_addr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE:    if (bus.frameStart) state_d = COLLECT;
         COLLECT: if (bus.frameEnd)   state_d = DRAIN;
         DRAIN:   if (empty)          state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if ((state_q == IDLE) && bus.frameStart) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (qual) begin
         if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
         if (!push) overflow_d = 1'b1;
      end

      // Registered head: when the only next entry is the one being written now,
      // take it from refAddr since the memory write has not landed yet.
      if (rd_ptr_d != wr_ptr_d) begin
         if (rd_ptr_d == wr_ptr_q) out_addr_d = bus.refAddr;
         else                      out_addr_d = mem_q[rd_ptr_d[AW-1:0]];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_addr_q <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         out_addr_q <= out_addr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.refAddr;
   end

   assign bus.outValid    = !empty;
   assign bus.outAddr     = out_addr_q;
   assign bus.cornerCount = count_q;
   assign bus.overflow    = overflow_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.frameDone   = (state_q == DONE);
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_fd_corner_collector.sv
// Randomized scoreboard bench for fd_corner_collector: a queue-based frame model
// predicts every emitted address plus count/overflow/busy/frameDone each cycle.
module tb_fd_corner_collector;
   localparam int ADDR_W = 15;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = 16;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fd_corner_collector_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   fd_corner_collector #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;
   int done_pulses = 0;

   logic [ADDR_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] mdl_fifo[$];
   int                mdl_phase = 0;
   int                mdl_cnt = 0;
   bit                mdl_ovf = 1'b0;
   logic [ADDR_W-1:0] mdl_last = '0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame phase 0 idle, 1 collecting, 2 draining, 3 done.
   always @(posedge clock) begin
      bit mdl_pop;
      bit mdl_qual;
      if (reset) begin
         mdl_phase = 0;
         mdl_cnt   = 0;
         mdl_ovf   = 1'b0;
         mdl_last  = '0;
         mdl_fifo.delete();
         exp_q.delete();
      end else begin
         mdl_pop  = (mdl_fifo.size() > 0) && bus.outReady;
         mdl_qual = (mdl_phase == 1) && bus.inValid && bus.isCorner;
         if (mdl_qual) begin
            if (mdl_cnt < (1 << CNT_W) - 1) mdl_cnt++;
            if (mdl_fifo.size() < DEPTH || mdl_pop) begin
               mdl_fifo.push_back(bus.refAddr);
               exp_q.push_back(bus.refAddr);
            end else begin
               mdl_ovf = 1'b1;
            end
         end
         case (mdl_phase)
            0: if (bus.frameStart) begin
                  mdl_phase = 1;
                  mdl_cnt   = 0;
                  mdl_ovf   = 1'b0;
               end
            1: if (bus.frameEnd) mdl_phase = 2;
            2: if (mdl_fifo.size() == 0 || (mdl_pop && mdl_qual && mdl_fifo.size() == 1 && 0)) mdl_phase = 3;
            default: mdl_phase = 0;
         endcase
         if (mdl_pop) void'(mdl_fifo.pop_front());
         if (mdl_fifo.size() > 0) mdl_last = mdl_fifo[0];
      end
   end

   // Monitor: compares presented output and status, pops on each transfer.
   always @(negedge clock) begin
      if (!reset) begin
         check("out_valid", bus.outValid, (exp_q.size() > 0));
         if (exp_q.size() > 0) check("out_addr", bus.outAddr, exp_q[0]);
         else                  check("out_addr_hold", bus.outAddr, mdl_last);
         check("corner_count", bus.cornerCount, mdl_cnt);
         check("overflow", bus.overflow, mdl_ovf);
         check("busy", bus.busy, (mdl_phase != 0));
         check("frame_done", bus.frameDone, (mdl_phase == 3));
         if (bus.frameDone) done_pulses++;
         if (bus.outValid && bus.outReady && exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   task automatic cyc(input bit fs, input bit fe, input bit iv, input bit ic,
                      input logic [ADDR_W-1:0] addr, input bit rdy);
      bus.frameStart = fs;
      bus.frameEnd   = fe;
      bus.inValid    = iv;
      bus.isCorner   = ic;
      bus.refAddr    = addr;
      bus.outReady   = rdy;
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input int budget, input bit rand_rdy);
      int n = 0;
      while ((mdl_phase != 0 || mdl_fifo.size() > 0) && n < budget) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end
      check("drain_timeout", (n < budget), 1);
   endtask

   initial begin
      reset = 1'b1;
      cyc(0, 0, 0, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 0);
      reset = 1'b0;
      cyc(0, 0, 0, 0, '0, 0);

      // T1: reset while draining with 5 entries held
      cyc(1, 0, 0, 0, '0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, ADDR_W'(16'h0100 + i), 0);
      cyc(0, 1, 0, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 0);
      reset = 1'b1;
      cyc(0, 0, 0, 0, '0, 0);
      reset = 1'b0;
      check("t1_out_valid", bus.outValid, 0);
      check("t1_busy", bus.busy, 0);
      check("t1_count", bus.cornerCount, 0);
      check("t1_overflow", bus.overflow, 0);
      cyc(0, 0, 0, 0, '0, 1);

      // T2: three corners including the top address
      done_pulses = 0;
      cyc(1, 0, 0, 0, '0, 0);
      cyc(0, 0, 1, 1, 15'h0010, 0);
      cyc(0, 0, 1, 1, 15'h0011, 0);
      cyc(0, 0, 1, 1, 15'h7FFF, 0);
      cyc(0, 1, 0, 0, '0, 1);
      drain(200, 1'b0);
      check("t2_count", bus.cornerCount, 3);
      check("t2_done_pulses", done_pulses, 1);

      // T3: 70 corners against a stalled consumer
      cyc(1, 0, 0, 0, '0, 0);
      for (int i = 0; i < 70; i++) cyc(0, 0, 1, 1, ADDR_W'(16'h2000 + i), 0);
      check("t3_overflow", bus.overflow, 1);
      check("t3_count", bus.cornerCount, 70);
      cyc(0, 1, 0, 0, '0, 0);
      drain(300, 1'b0);

      // T4: full FIFO, push and pop in the same cycle
      cyc(1, 0, 0, 0, '0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 1, ADDR_W'(16'h3000 + i), 0);
      check("t4_full_no_ovf", bus.overflow, 0);
      cyc(0, 0, 1, 1, 15'h3FFF, 1);
      check("t4_pushpop_ovf", bus.overflow, 0);
      check("t4_count", bus.cornerCount, DEPTH + 1);
      cyc(0, 1, 0, 0, '0, 0);
      drain(300, 1'b0);

      // T5: corners while idle, then a frame of non-corners
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, ADDR_W'($urandom), 0);
      check("t5_idle_empty", bus.outValid, 0);
      cyc(1, 0, 0, 0, '0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 0, 1, 0, ADDR_W'($urandom), 1);
      cyc(0, 1, 0, 0, '0, 1);
      drain(50, 1'b0);
      check("t5_count", bus.cornerCount, 0);
      check("t5_empty", bus.outValid, 0);

      // T6: corner on the frameEnd cycle; done must wait for its pop
      done_pulses = 0;
      cyc(1, 0, 0, 0, '0, 0);
      cyc(0, 0, 1, 1, 15'h0042, 0);
      cyc(0, 1, 1, 1, 15'h1234, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, '0, 0);
      check("t6_no_early_done", done_pulses, 0);
      check("t6_count", bus.cornerCount, 2);
      drain(100, 1'b0);
      check("t6_done_pulses", done_pulses, 1);

      // Random frames with stray frameStart pulses and a random consumer
      for (int f = 0; f < 8; f++) begin
         int gap = $urandom_range(0, 6);
         int len = $urandom_range(20, 150);
         for (int i = 0; i < gap; i++)
            cyc(0, 0, 1'($urandom), 1'($urandom), ADDR_W'($urandom), 1'($urandom));
         cyc(1, 0, 0, 0, '0, 1'($urandom));
         for (int i = 0; i < len; i++)
            cyc(($urandom_range(0, 15) == 0), 0, 1'($urandom), 1'($urandom),
                ADDR_W'($urandom), ($urandom_range(0, 3) == 0));
         cyc(0, 1, 1'($urandom), 1'($urandom), ADDR_W'($urandom), 1'($urandom));
         drain(1000, 1'b1);
      end

      cyc(0, 0, 0, 0, '0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
